// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with ARM-style carry-out and zero flag.
// One mux level per shift-amount bit, a register bank every LEVELS_PER_STAGE levels, and an elastic valid/ready pipeline.
module pipelined_barrel_shifter #(
    parameter int WIDTH            = 64,
    parameter int LEVELS_PER_STAGE = 2,
    localparam int SHAMT_W         = $clog2(WIDTH),
    localparam int NUM_STAGES      = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_zero
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } shiftMode_t;

    logic [NUM_STAGES-1:0] stValid;
    logic [NUM_STAGES-1:0] validSrc;
    logic [NUM_STAGES-1:0] en;

    // A stage may load when it is empty or when the stage after it is moving.
    always_comb begin
        en = '0;
        en[NUM_STAGES-1] = !stValid[NUM_STAGES-1] || out_ready;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            en[i] = !stValid[i] || en[i+1];
        end
    end

    always_comb begin
        validSrc = stValid << 1;
        validSrc[0] = in_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stValid <= '0;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (en[s]) begin
                    stValid[s] <= validSrc[s];
                end
            end
        end
    end

    assign in_ready = en[0];

    for (genvar s = 0; s < NUM_STAGES; s++) begin : gStage
        localparam int FIRST = s * LEVELS_PER_STAGE;
        localparam int NLV   = (SHAMT_W - FIRST < LEVELS_PER_STAGE) ? (SHAMT_W - FIRST) : LEVELS_PER_STAGE;

        logic [WIDTH-1:0]       srcData;
        logic                   srcCarry;
        shiftMode_t             srcMode;
        logic [SHAMT_W-1:FIRST] srcShamt;
        logic [WIDTH-1:0]       dataReg;
        logic                   carryReg;

        if (s == 0) begin : gSrc
            assign srcData  = in_data;
            assign srcCarry = in_carry;
            assign srcMode  = shiftMode_t'(in_mode);
            assign srcShamt = in_shamt;
        end else begin : gSrc
            assign srcData  = gStage[s-1].dataReg;
            assign srcCarry = gStage[s-1].carryReg;
            assign srcMode  = gStage[s-1].gFwd.resMode;
            assign srcShamt = gStage[s-1].gFwd.resShamt;
        end

        for (genvar j = 0; j < NLV; j++) begin : gLvl
            localparam int K   = FIRST + j;
            localparam int AMT = 1 << K;

            logic [WIDTH-1:0] dIn;
            logic [WIDTH-1:0] dShift;
            logic [WIDTH-1:0] dOut;
            logic             cIn;
            logic             cShift;
            logic             cOut;

            if (j == 0) begin : gIn
                assign dIn = srcData;
                assign cIn = srcCarry;
            end else begin : gIn
                assign dIn = gLvl[j-1].dOut;
                assign cIn = gLvl[j-1].cOut;
            end

            // Carry is the last bit leaving in this level; since levels run in
            // ascending order, the highest active level leaves the final carry.
            always_comb begin
                dShift = dIn;
                cShift = cIn;
                case (srcMode)
                    MODE_LSL: begin
                        dShift = {dIn[WIDTH-AMT-1:0], {AMT{1'b0}}};
                        cShift = dIn[WIDTH-AMT];
                    end
                    MODE_LSR: begin
                        dShift = {{AMT{1'b0}}, dIn[WIDTH-1:AMT]};
                        cShift = dIn[AMT-1];
                    end
                    MODE_ASR: begin
                        dShift = {{AMT{dIn[WIDTH-1]}}, dIn[WIDTH-1:AMT]};
                        cShift = dIn[AMT-1];
                    end
                    MODE_ROR: begin
                        dShift = {dIn[AMT-1:0], dIn[WIDTH-1:AMT]};
                        cShift = dIn[AMT-1];
                    end
                    default: begin
                        dShift = dIn;
                        cShift = cIn;
                    end
                endcase
            end

            assign dOut = srcShamt[K] ? dShift : dIn;
            assign cOut = srcShamt[K] ? cShift : cIn;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dataReg  <= '0;
                carryReg <= 1'b0;
            end else if (en[s]) begin
                dataReg  <= gLvl[NLV-1].dOut;
                carryReg <= gLvl[NLV-1].cOut;
            end
        end

        // Only the shift-amount bits still to be applied travel downstream.
        if (s < NUM_STAGES - 1) begin : gFwd
            shiftMode_t                 resMode;
            logic [SHAMT_W-1:FIRST+NLV] resShamt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    resMode  <= MODE_LSL;
                    resShamt <= '0;
                end else if (en[s]) begin
                    resMode  <= srcMode;
                    resShamt <= srcShamt[SHAMT_W-1:FIRST+NLV];
                end
            end
        end else begin : gZero
            logic zeroReg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    zeroReg <= 1'b0;
                end else if (en[s]) begin
                    zeroReg <= (gLvl[NLV-1].dOut == '0);
                end
            end
        end
    end

    assign out_valid = stValid[NUM_STAGES-1];
    assign out_data  = gStage[NUM_STAGES-1].dataReg;
    assign out_carry = gStage[NUM_STAGES-1].carryReg;
    assign out_zero  = gStage[NUM_STAGES-1].gZero.zeroReg;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and streaming checks of pipelined_barrel_shifter at WIDTH=64, three stages.
module tb_pipelined_barrel_shifter;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_carry;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] d;
        logic [5:0]  sh;
        logic [1:0]  m;
        logic        cin;
        logic [63:0] expD;
        logic        expC;
    } vec_t;

    pipelined_barrel_shifter #(.WIDTH(64), .LEVELS_PER_STAGE(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_zero(out_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Bit-serial reference: one single-bit shift per step, carry is the last bit out.
    function automatic logic [64:0] refShift(input logic [63:0] d, input int n, input logic [1:0] m, input logic cin);
        logic [63:0] r;
        logic        c;
        r = d;
        c = cin;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00:   begin c = r[63]; r = {r[62:0], 1'b0}; end
                2'b01:   begin c = r[0];  r = {1'b0, r[63:1]}; end
                2'b10:   begin c = r[0];  r = {r[63], r[63:1]}; end
                default: begin c = r[0];  r = {r[0], r[63:1]}; end
            endcase
        end
        return {c, r};
    endfunction

    // Issues one operation into an empty pipeline and returns cycles until out_valid (-1 on timeout).
    task automatic runOp(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] m, input logic c, output int lat);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = m; in_carry = c; out_ready = 1'b1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = LSL; in_carry = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL reset_flags: got carry=%b zero=%b expected 0 0", out_carry, out_zero); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_lsl;
        int lat;
        runOp(64'h0123456789123456, 6'd2, LSL, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lsl_latency: got %0d expected 3", lat); end
        checks++; if (out_data !== 64'h048D159E2448D158) begin errors++; $display("FAIL lsl_data: got %h expected 048d159e2448d158", out_data); end
        checks++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL lsl_flags: got carry=%b zero=%b expected 0 0", out_carry, out_zero); end
    endtask

    task automatic test_modes;
        vec_t v[12];
        int   lat;
        v[0]  = '{64'h8000000000000000, 6'd4,  ASR, 1'b0, 64'hF800000000000000, 1'b0};
        v[1]  = '{64'h00000000000000AB, 6'd8,  ROR, 1'b0, 64'hAB00000000000000, 1'b1};
        v[2]  = '{64'h0000000000000001, 6'd1,  LSR, 1'b0, 64'h0000000000000000, 1'b1};
        v[3]  = '{64'h000000000000DEAD, 6'd0,  LSL, 1'b1, 64'h000000000000DEAD, 1'b1};
        v[4]  = '{64'h8000000000000001, 6'd1,  LSL, 1'b0, 64'h0000000000000002, 1'b1};
        v[5]  = '{64'h0000000000000001, 6'd63, LSL, 1'b0, 64'h8000000000000000, 1'b0};
        v[6]  = '{64'h8000000000000000, 6'd63, ASR, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        v[7]  = '{64'hC000000000000000, 6'd63, LSR, 1'b0, 64'h0000000000000001, 1'b1};
        v[8]  = '{64'h0000000000000003, 6'd1,  ROR, 1'b0, 64'h8000000000000001, 1'b1};
        v[9]  = '{64'h0000000000001234, 6'd0,  ROR, 1'b0, 64'h0000000000001234, 1'b0};
        v[10] = '{64'h7000000000000000, 6'd4,  ASR, 1'b1, 64'h0700000000000000, 1'b0};
        v[11] = '{64'h00000000FFFFFFFF, 6'd32, ROR, 1'b0, 64'hFFFFFFFF00000000, 1'b1};
        for (int i = 0; i < 12; i++) begin
            runOp(v[i].d, v[i].sh, v[i].m, v[i].cin, lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL mode_latency[%0d]: got %0d expected 3", i, lat); end
            checks++; if (out_data !== v[i].expD) begin errors++; $display("FAIL mode_data[%0d]: got %h expected %h", i, out_data, v[i].expD); end
            checks++; if (out_carry !== v[i].expC) begin errors++; $display("FAIL mode_carry[%0d]: got %b expected %b", i, out_carry, v[i].expC); end
            checks++; if (out_zero !== (v[i].expD == 64'h0)) begin errors++; $display("FAIL mode_zero[%0d]: got %b expected %b", i, out_zero, (v[i].expD == 64'h0)); end
        end
    endtask

    task automatic test_back_to_back;
        int          idx;
        int          got;
        int          cyc;
        int          lastCyc;
        logic        rdy;
        logic [63:0] held;
        idx = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = (idx < 5); in_data = 64'h1; in_shamt = 6'(idx + 1); in_mode = LSL; in_carry = 1'b0;
            #1 rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (idx !== 3) begin errors++; $display("FAIL stall_accepts: got %0d expected 3", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h2) begin errors++; $display("FAIL stall_head: got valid=%b data=%h expected 1 0000000000000002", out_valid, out_data); end
        held = out_data;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL stall_stable: got valid=%b data=%h expected 1 %h", out_valid, out_data, held); end
        got = 0; cyc = 0; lastCyc = -1;
        while (got < 5 && cyc < 20) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 5); in_data = 64'h1; in_shamt = 6'(idx + 1); in_mode = LSL; in_carry = 1'b0;
            #1 rdy = in_ready;
            if (out_valid) begin
                checks++; if (out_data !== (64'h1 << (got + 1))) begin errors++; $display("FAIL drain_order[%0d]: got %h expected %h", got, out_data, 64'h1 << (got + 1)); end
                if (lastCyc >= 0) begin
                    checks++; if (cyc - lastCyc !== 1) begin errors++; $display("FAIL drain_rate[%0d]: got gap %0d expected 1", got, cyc - lastCyc); end
                end
                lastCyc = cyc;
                got++;
            end
            @(posedge clk);
            if (in_valid && rdy) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (got !== 5) begin errors++; $display("FAIL drain_count: got %0d expected 5", got); end
    endtask

    task automatic test_reset_flight;
        int seen;
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h1; in_shamt = 6'd1; in_mode = LSL; in_carry = 1'b0;
        @(negedge clk);
        in_data = 64'h4; in_shamt = 6'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_pre_valid: got %b expected 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin errors++; $display("FAIL flight_reset_now: got valid=%b data=%h expected 0 0", out_valid, out_data); end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flight_ghost: got %0d results expected 0", seen); end
        runOp(64'h00000000000000F0, 6'd4, LSR, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL flight_next_latency: got %0d expected 3", lat); end
        checks++; if (out_data !== 64'hF || out_carry !== 1'b0) begin errors++; $display("FAIL flight_next_data: got %h c=%b expected 000000000000000f c=0", out_data, out_carry); end
    endtask

    task automatic test_stream;
        logic [64:0] q[$];
        logic [64:0] exp;
        logic        rdy;
        logic        prevHold;
        logic [63:0] prevData;
        logic        prevCarry;
        int          budget;
        prevHold = 1'b0; prevData = '0; prevCarry = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            in_shamt  = 6'($urandom_range(0, 63));
            in_mode   = 2'($urandom_range(0, 3));
            in_carry  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1 rdy = in_ready;
            if (prevHold) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prevData || out_carry !== prevCarry) begin errors++; $display("FAIL stream_hold: got v=%b %h c=%b expected v=1 %h c=%b", out_valid, out_data, out_carry, prevData, prevCarry); end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL stream_extra: got unexpected result %h expected none", out_data);
                end else begin
                    exp = q.pop_front();
                    checks++; if (out_data !== exp[63:0] || out_carry !== exp[64]) begin errors++; $display("FAIL stream_result: got %h c=%b expected %h c=%b", out_data, out_carry, exp[63:0], exp[64]); end
                    checks++; if (out_zero !== (exp[63:0] == 64'h0)) begin errors++; $display("FAIL stream_zero: got %b expected %b", out_zero, (exp[63:0] == 64'h0)); end
                end
            end
            prevHold = out_valid && !out_ready;
            prevData = out_data; prevCarry = out_carry;
            if (in_valid && rdy) q.push_back(refShift(in_data, int'(in_shamt), in_mode, in_carry));
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 50) begin
            #1;
            if (out_valid) begin
                exp = q.pop_front();
                checks++; if (out_data !== exp[63:0] || out_carry !== exp[64]) begin errors++; $display("FAIL drain_result: got %h c=%b expected %h c=%b", out_data, out_carry, exp[63:0], exp[64]); end
            end
            @(negedge clk);
            budget++;
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL stream_lost: got %0d outstanding expected 0", q.size()); end
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_dup: got out_valid=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_modes();
        test_back_to_back();
        test_reset_flight();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
